// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with a one-entry valid/ready output register,
// flush, and a retired-operation counter.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH),
  // Counter width; narrower values only shorten the wrap period for testing.
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [31:0]      op_count
);

  typedef enum logic [3:0] {
    OpAdd  = 4'b0000,
    OpSub  = 4'b0001,
    OpAnd  = 4'b0010,
    OpOr   = 4'b0011,
    OpSll  = 4'b0100,
    OpSlt  = 4'b0101,
    OpXor  = 4'b0110,
    OpSrl  = 4'b0111,
    OpSltu = 4'b1000,
    OpSra  = 4'b1111
  } alu_op_e;

  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic             alu_zero;
  logic [SHW-1:0]   shamt;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept;
  logic             retire;

  // ---------------------------------------------------------------------------
  // Combinational ALU datapath
  // ---------------------------------------------------------------------------
  assign shamt = srcb[SHW-1:0];

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alu_op_e'(alucontrol))
      OpAdd:  alu_res = srca + srcb;
      OpSub:  alu_res = srca - srcb;
      OpAnd:  alu_res = srca & srcb;
      OpOr:   alu_res = srca | srcb;
      OpXor:  alu_res = srca ^ srcb;
      OpSll:  alu_res = srca << shamt;
      OpSrl:  alu_res = srca >> shamt;
      OpSra:  alu_res = $unsigned($signed(srca) >>> shamt);
      OpSlt:  alu_res[0] = $signed(srca) < $signed(srcb);
      OpSltu: alu_res[0] = srca < srcb;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = valid_q && out_ready && !flush;

  // Flush wins over both accept and retire; accept wins over the retire clear.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else begin
      if (retire) begin
        valid_d = 1'b0;
        count_d = count_q + 1'b1;
      end
      if (accept) begin
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      // Payload only loads on accept, so idle-cycle operands never leak in.
      if (accept) begin
        result_q  <= alu_res;
        zero_q    <= alu_zero;
        illegal_q <= alu_illegal;
      end
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign op_count  = 32'(count_q);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage; the counter is shortened to
// 4 bits so the wrap-to-zero case is reachable.
`define TB_COUNT_WIDTH 4

module tb_alu_exec_stage;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [31:0]      op_count;

  int n_cmp;
  int n_err;

  alu_exec_stage #(
    .WIDTH (WIDTH),
    .CNT_W (`TB_COUNT_WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal    (illegal),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid   = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    alucontrol = 4'hx;
    srca       = 'x;
    srcb       = 'x;
  endtask

  task automatic check_out(input string tag, input logic [31:0] res, input logic z,
                           input logic ill, input logic [31:0] cnt);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".result"}, result, res);
    check({tag, ".zero"}, 32'(zero), 32'(z));
    check({tag, ".illegal"}, 32'(illegal), 32'(ill));
    check({tag, ".count"}, op_count, cnt);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle();
    tick();
    tick();

    // Reset state
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    check("rst.count", op_count, 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    // Basic ops, streaming with out_ready high; each accept retires the previous result
    drive(4'b0000, 32'd5, 32'd7);               tick(); check_out("add", 32'd12, 1'b0, 1'b0, 32'd0);
    drive(4'b0001, 32'd7, 32'd7);               tick(); check_out("sub", 32'd0, 1'b1, 1'b0, 32'd1);
    drive(4'b1111, 32'h8000_0000, 32'h24);      tick(); check_out("sra", 32'hF800_0000, 1'b0, 1'b0, 32'd2);
    drive(4'b0111, 32'h8000_0000, 32'h24);      tick(); check_out("srl", 32'h0800_0000, 1'b0, 1'b0, 32'd3);
    drive(4'b0101, 32'hFFFF_FFFF, 32'd1);       tick(); check_out("slt", 32'd1, 1'b0, 1'b0, 32'd4);
    drive(4'b1000, 32'hFFFF_FFFF, 32'd1);       tick(); check_out("sltu", 32'd0, 1'b1, 1'b0, 32'd5);
    drive(4'b0100, 32'd1, 32'd31);              tick(); check_out("sll", 32'h8000_0000, 1'b0, 1'b0, 32'd6);
    drive(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0); tick(); check_out("illegal", 32'd0, 1'b1, 1'b1, 32'd7);

    // Drain: illegal op retires, stage empties
    idle();
    tick();
    check("drain.valid", 32'(out_valid), 32'd0);
    check("drain.count", op_count, 32'd8);

    // Back-pressure: add 1+1 held for three stalled cycles while a new op is offered
    out_ready = 1'b0;
    drive(4'b0000, 32'd1, 32'd1);
    tick();
    check_out("bp.load", 32'd2, 1'b0, 1'b0, 32'd8);
    drive(4'b0000, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
      check_out("bp.hold", 32'd2, 1'b0, 1'b0, 32'd8);
    end
    out_ready = 1'b1;
    drive(4'b0110, 32'hF0, 32'h0F);
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    tick();
    check_out("bp.xor", 32'hFF, 1'b0, 1'b0, 32'd9);

    // Flush: stall, then flush with an offered op and out_ready high
    out_ready = 1'b0;
    idle();
    tick();
    check_out("fl.stall", 32'hFF, 1'b0, 1'b0, 32'd9);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(4'b0000, 32'd3, 32'd4);
    tick();
    check("fl.valid", 32'(out_valid), 32'd0);
    check("fl.result", result, 32'hFF);
    check("fl.count", op_count, 32'd9);
    flush = 1'b0;
    idle();
    tick();
    check("fl.after_valid", 32'(out_valid), 32'd0);
    check("fl.after_count", op_count, 32'd9);

    // Wrap of the shortened counter: seven more retires take 9 -> 15 -> 0
    for (int i = 0; i < 7; i++) begin
      drive(4'b0000, 32'(i), 32'(i));
      tick();
    end
    check_out("wrap.max", 32'd12, 1'b0, 1'b0, 32'd15);
    idle();
    tick();
    check("wrap.valid", 32'(out_valid), 32'd0);
    check("wrap.count", op_count, 32'd0);

    // Reset with a result in flight and a retire pending
    drive(4'b0000, 32'd2, 32'd3);
    tick();
    check_out("rst2.pre", 32'd5, 1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    drive(4'b1010, 32'd1, 32'd1);
    tick();
    check("rst2.valid", 32'(out_valid), 32'd0);
    check("rst2.result", result, 32'd0);
    check("rst2.zero", 32'(zero), 32'd0);
    check("rst2.illegal", 32'(illegal), 32'd0);
    check("rst2.count", op_count, 32'd0);
    check("rst2.in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
